// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Magnitude of v when it is to be read as signed, otherwise v unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/writeback bundle between the issue stage and the multiply/divide unit.
interface muldiv_if;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd_addr;
    logic        o_busy;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;

    modport master (
        output i_start, i_op, i_rs1_data, i_rs2_data, i_rd_addr,
        input  o_busy, o_rd_addr, o_rd_data, o_rd_wren
    );

    modport slave (
        input  i_start, i_op, i_rs1_data, i_rs2_data, i_rd_addr,
        output o_busy, o_rd_addr, o_rd_data, o_rd_wren
    );
endinterface

// File: rtl/muldiv_divcore.sv
// Unsigned restoring divider on operand magnitudes: one quotient bit per step.
// Latency is set by the caller (32 steps); load and step are never asserted together.
module muldiv_divcore (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = shifted >= {1'b0, dvs_q};
        diff    = shifted[31:0] - dvs_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? diff : shifted[31:0];
            quo_q <= {quo_q[30:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 33-cycle iterative shift-add multiply and restoring divide.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply (IDLE->DONE at accept); divides unchanged.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset,
    muldiv_if.slave  bus
);
    state_e      state;
    op_e         op_q;
    op_e         op_in;
    logic [4:0]  count;
    logic [4:0]  rd_addr_q;
    logic [31:0] mcand;
    logic [63:0] prod;
    logic        neg_p, neg_q, neg_r;
    logic        busy, wren;
    logic        a_signed, b_signed;
    logic [31:0] a_mag, b_mag;
    logic        fast_take;
    logic [63:0] fast_prod;
    logic [32:0] psum;
    logic [63:0] prod_fix;
    logic [31:0] quo, rem, res;

    always_comb begin
        op_in    = op_e'(bus.i_op);
        a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
        a_mag    = mag32(bus.i_rs1_data, a_signed);
        b_mag    = mag32(bus.i_rs2_data, b_signed);
        psum     = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [65:0] fast_full;
    always_comb begin
        fast_a    = {a_signed & bus.i_rs1_data[31], bus.i_rs1_data};
        fast_b    = {b_signed & bus.i_rs2_data[31], bus.i_rs2_data};
        fast_full = fast_a * fast_b;
        fast_prod = fast_full[63:0];
        fast_take = !bus.i_op[2];
    end
`else
    always_comb begin
        fast_prod = '0;
        fast_take = 1'b0;
    end
`endif

    muldiv_divcore u_divcore (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .load      (state == ST_IDLE && bus.i_start),
        .step      (state == ST_RUN && op_q[2]),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            count     <= '0;
            rd_addr_q <= '0;
            mcand     <= '0;
            prod      <= '0;
            neg_p     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            wren      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.i_start) begin
                    op_q      <= op_in;
                    rd_addr_q <= bus.i_rd_addr;
                    mcand     <= a_mag;
                    count     <= '0;
                    busy      <= 1'b1;
                    // Quotient sign is left alone for a zero divisor so it stays all ones.
                    neg_q     <= b_signed & (bus.i_rs1_data[31] ^ bus.i_rs2_data[31])
                                 & (bus.i_rs2_data != 32'd0);
                    neg_r     <= a_signed & bus.i_rs1_data[31];
                    if (fast_take) begin
                        prod  <= fast_prod;
                        neg_p <= 1'b0;
                        wren  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        prod  <= {32'd0, b_mag};
                        neg_p <= (a_signed & bus.i_rs1_data[31]) ^ (b_signed & bus.i_rs2_data[31]);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!op_q[2])
                        prod <= {psum, prod[31:1]};
                    count <= count + 5'd1;
                    if (count == 5'(MULDIV_ITER - 1)) begin
                        wren  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    wren  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        prod_fix = neg_p ? 64'(-prod) : prod;
        case (op_q)
            OP_MUL:                       res = prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[63:32];
            OP_DIV, OP_DIVU:              res = neg_q ? 32'(-quo) : quo;
            default:                      res = neg_r ? 32'(-rem) : rem;
        endcase
    end

    assign bus.o_busy    = busy;
    assign bus.o_rd_wren = wren;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_rd_data = wren ? res : 32'd0;
endmodule
